// File: rtl/key_matrix_scan.sv
// Row-scanning matrix keypad controller.
// One row is driven low per slot. Columns are sampled mid-slot through a
// 2-flop synchroniser. Each key is debounced across scan frames. Debounced
// flips are reported as a state bitmap, as one-cycle pulses, and as a
// single-entry valid/ready event register.

// Per-key debounce cell: counts consecutive disagreeing samples and flips.
module key_matrix_scan_cell #(
  parameter int DEBOUNCE = 2,
  parameter int DW       = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,   // this key's row is being sampled this edge
  input  logic s,        // sampled level, 1 = pressed
  output logic state,
  output logic press_p,
  output logic rel_p,
  output logic flip      // state flips on this edge
);
  logic [DW-1:0] dcnt;

  assign flip = sample && (s != state) && (dcnt == DW'(DEBOUNCE - 1));

  // debounce counter, debounced state and one-cycle edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt    <= '0;
      state   <= 1'b0;
      press_p <= 1'b0;
      rel_p   <= 1'b0;
    end else begin
      press_p <= 1'b0;
      rel_p   <= 1'b0;
      if (sample) begin
        if (s == state) begin
          dcnt <= '0;
        end else if (flip) begin
          state   <= s;
          dcnt    <= '0;
          press_p <= s;
          rel_p   <= ~s;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end
    end
  end
endmodule

module key_matrix_scan #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SLOT_CYCLES   = 250000,
  parameter int SAMPLE_OFFSET = 125000,
  parameter int DEBOUNCE      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scan_en,
  input  logic [COLS-1:0]               col_in,
  output logic [ROWS-1:0]               row_out,
  output logic [ROWS*COLS-1:0]          key_state,
  output logic [ROWS*COLS-1:0]          press_pulse,
  output logic [ROWS*COLS-1:0]          release_pulse,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(ROWS*COLS)-1:0]  ev_code,
  output logic                          ev_press,
  output logic                          overflow
);
  localparam int KW  = $clog2(ROWS*COLS);
  localparam int CW  = $clog2(SLOT_CYCLES);
  localparam int RW  = $clog2(ROWS);
  localparam int CCW = $clog2(COLS);
  localparam int DW  = $clog2(DEBOUNCE + 1);

  logic [COLS-1:0] sync1, sync2;
  logic [CW-1:0]   slot_cnt;
  logic [RW-1:0]   row;
  logic            sample;

  logic [ROWS-1:0][COLS-1:0] flip_mat, st_mat, pr_mat, rl_mat;
  logic [COLS-1:0]           row_flips;
  logic                      found, multi;
  logic [CCW-1:0]            cand_col;
  logic [KW-1:0]             cand_code;
  logic                      cand_press;

  // column synchroniser; idles high like the pulled-up columns
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= col_in;
      sync2 <= sync1;
    end
  end

  // slot counter, row index and registered row drive (one cycle behind row)
  always_ff @(posedge clk) begin
    if (rst || !scan_en) begin
      slot_cnt <= '0;
      row      <= '0;
      row_out  <= '1;
    end else begin
      row_out <= ~(ROWS'(1) << row);
      if (slot_cnt == CW'(SLOT_CYCLES - 1)) begin
        slot_cnt <= '0;
        row      <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
      end
    end
  end

  assign sample = scan_en && (slot_cnt == CW'(SAMPLE_OFFSET));

  // key cell array; only the currently driven row sees a sample strobe
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      key_matrix_scan_cell #(.DEBOUNCE(DEBOUNCE), .DW(DW)) u_cell (
        .clk     (clk),
        .rst     (rst),
        .sample  (sample && (row == RW'(r))),
        .s       (~sync2[c]),
        .state   (st_mat[r][c]),
        .press_p (pr_mat[r][c]),
        .rel_p   (rl_mat[r][c]),
        .flip    (flip_mat[r][c])
      );
    end
  end

  assign key_state     = st_mat;
  assign press_pulse   = pr_mat;
  assign release_pulse = rl_mat;
  assign row_flips     = flip_mat[row];

  // pick the lowest-column flip of the sampled row; note any extras
  always_comb begin
    found    = 1'b0;
    multi    = 1'b0;
    cand_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (row_flips[c]) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          found    = 1'b1;
          cand_col = CCW'(c);
        end
      end
    end
    cand_code  = KW'(row) * KW'(COLS) + KW'(cand_col);
    cand_press = ~sync2[cand_col];
  end

  // single-entry event holding register with sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_code  <= '0;
      ev_press <= 1'b0;
      overflow <= 1'b0;
    end else if (found) begin
      if (!ev_valid || ev_ready) begin
        ev_valid <= 1'b1;
        ev_code  <= cand_code;
        ev_press <= cand_press;
      end else begin
        overflow <= 1'b1;
      end
      if (multi) overflow <= 1'b1;
    end else if (ev_valid && ev_ready) begin
      ev_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: directed scenarios followed by random key,
// enable, reset and backpressure activity, all compared every cycle against
// a frame-schedule reference model.
module tb_key_matrix_scan;
  localparam int ROWS = 4, COLS = 4, SLOT = 16, OFF = 8, DEB = 2, NK = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_en = 1'b0;
  logic        ev_ready = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] key_state, press_pulse, release_pulse;
  logic        ev_valid;
  logic [3:0]  ev_code;
  logic        ev_press, overflow;
  logic [15:0] keys = '0;

  always #5 clk = ~clk;

  key_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .SLOT_CYCLES(SLOT), .SAMPLE_OFFSET(OFF), .DEBOUNCE(DEB)
  ) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .col_in(col_in), .row_out(row_out),
    .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_press(ev_press),
    .overflow(overflow)
  );

  // keypad: a pressed key shorts its row to its column
  always_comb begin
    col_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_out[r] && keys[r*COLS+c]) col_in[c] = 1'b0;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: edge k after (re)enable drives row (k/SLOT)%ROWS and
  // samples when k%SLOT == OFF, using the column level from two edges back
  logic [3:0]  m_row_out = 4'hF;
  logic [15:0] m_state = '0, m_press = '0, m_rel = '0;
  int          m_cnt [NK];
  logic        m_valid = 1'b0, m_evp = 1'b0, m_ovf = 1'b0;
  logic [3:0]  m_code = '0;
  int          m_n = 0;
  logic [3:0]  m_s1 = 4'hF, m_s2 = 4'hF;

  always @(posedge clk) begin : model
    logic [3:0] seen;
    int r, k, nflip;
    logic [3:0] fcode;
    logic fpress, s;
    seen = '1;
    for (int rr = 0; rr < ROWS; rr++)
      for (int c = 0; c < COLS; c++)
        if (!m_row_out[rr] && keys[rr*COLS+c]) seen[c] = 1'b0;
    if (rst) begin
      m_row_out = 4'hF; m_state = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < NK; i++) m_cnt[i] = 0;
      m_valid = 1'b0; m_code = '0; m_evp = 1'b0; m_ovf = 1'b0;
      m_n = 0; m_s1 = 4'hF; m_s2 = 4'hF;
    end else begin
      m_press = '0; m_rel = '0; nflip = 0; fcode = '0; fpress = 1'b0;
      if (scan_en) begin
        r = (m_n / SLOT) % ROWS;
        if (m_n % SLOT == OFF) begin
          for (int c = 0; c < COLS; c++) begin
            k = r*COLS + c;
            s = !m_s2[c];
            if (s == m_state[k]) m_cnt[k] = 0;
            else begin
              m_cnt[k]++;
              if (m_cnt[k] == DEB) begin
                m_cnt[k] = 0;
                m_state[k] = s;
                if (s) m_press[k] = 1'b1; else m_rel[k] = 1'b1;
                if (nflip == 0) begin fcode = 4'(k); fpress = s; end
                nflip++;
              end
            end
          end
        end
        m_row_out = ~(4'b0001 << r);
        m_n++;
      end else begin
        m_row_out = 4'hF;
        m_n = 0;
      end
      if (nflip > 0) begin
        if (nflip > 1) m_ovf = 1'b1;
        if (!m_valid || ev_ready) begin
          m_valid = 1'b1; m_code = fcode; m_evp = fpress;
        end else m_ovf = 1'b1;
      end else if (m_valid && ev_ready) m_valid = 1'b0;
      m_s2 = m_s1;
      m_s1 = seen;
    end
  end

  // per-cycle comparison against the model plus a few event monitors
  int p6 = 0, r6 = 0, xfers = 0, cyc = 0, c8 = 0, c11 = 0;
  logic [3:0] last_code = '0;
  logic last_press = 1'b0;

  always @(negedge clk) begin
    cyc++;
    chk("row_out", row_out, m_row_out);
    chk("key_state", key_state, m_state);
    chk("press_pulse", press_pulse, m_press);
    chk("release_pulse", release_pulse, m_rel);
    chk("ev_valid", ev_valid, m_valid);
    if (m_valid) begin
      chk("ev_code", ev_code, m_code);
      chk("ev_press", ev_press, m_evp);
    end
    chk("overflow", overflow, m_ovf);
    if (press_pulse[6]) p6++;
    if (release_pulse[6]) r6++;
    if (press_pulse[8]) c8 = cyc;
    if (press_pulse[11]) c11 = cyc;
    if (ev_valid && ev_ready) begin
      xfers++; last_code = ev_code; last_press = ev_press;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin : stim
    logic [15:0] ks;
    int x0;
    // reset and row sequence
    rst = 1'b1; scan_en = 1'b1; ev_ready = 1'b1; keys = '0;
    step(3);
    chk("rst_row_out", row_out, 4'hF);
    chk("rst_key_state", key_state, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    step(1);  chk("row0", row_out, 4'hE);
    step(16); chk("row1", row_out, 4'hD);
    step(16); chk("row2", row_out, 4'hB);
    step(16); chk("row3", row_out, 4'h7);
    step(16); chk("row_wrap", row_out, 4'hE);

    // held press and release of key 6
    keys[6] = 1'b1; step(192);
    chk("k6_state", key_state[6], 1);
    chk("k6_press_cnt", p6, 1);
    chk("k6_ev_code", last_code, 6);
    chk("k6_ev_press", last_press, 1);
    keys[6] = 1'b0; step(192);
    chk("k6_released", key_state[6], 0);
    chk("k6_rel_cnt", r6, 1);
    chk("k6_rel_ev", last_press, 0);

    // one-frame bounce is ignored
    x0 = xfers;
    keys[6] = 1'b1; step(64); keys[6] = 1'b0; step(192);
    chk("bounce_state", key_state[6], 0);
    chk("bounce_pulse", p6, 1);
    chk("bounce_ev", xfers, x0);

    // backpressure: second event dropped
    ev_ready = 1'b0;
    keys[0] = 1'b1; step(192);
    keys[5] = 1'b1; step(192);
    chk("bp_valid", ev_valid, 1);
    chk("bp_code", ev_code, 0);
    chk("bp_overflow", overflow, 1);
    chk("bp_k5_state", key_state[5], 1);
    x0 = xfers;
    ev_ready = 1'b1; step(1);
    chk("bp_drained", ev_valid, 0);
    chk("bp_one_xfer", xfers, x0 + 1);
    chk("bp_ovf_sticky", overflow, 1);

    // two flips in one row
    keys = '0; step(192);
    rst = 1'b1; step(2); rst = 1'b0;
    keys[8] = 1'b1; keys[11] = 1'b1; step(192);
    chk("same_row_states", {key_state[11], key_state[8]}, 2'b11);
    chk("same_row_seen", c8 > 0, 1);
    chk("same_row_cycle", c11, c8);
    chk("same_row_code", last_code, 8);
    chk("same_row_ovf", overflow, 1);

    // scan disable freezes state
    keys = '0; step(192);
    keys[3] = 1'b1; step(192);
    chk("k3_state", key_state[3], 1);
    step(20);
    scan_en = 1'b0; step(1);
    chk("dis_rows", row_out, 4'hF);
    ks = key_state;
    keys[3] = 1'b0; step(200);
    chk("dis_frozen_a", key_state, ks);
    keys[3] = 1'b1; step(50); keys[3] = 1'b0; step(50);
    chk("dis_frozen_b", key_state, ks);
    scan_en = 1'b1; step(1);
    chk("reen_row0", row_out, 4'hE);

    // reset during key 6's first debounce frame discards the partial count
    keys = '0; rst = 1'b1; step(1); rst = 1'b0;
    keys[6] = 1'b1; step(40);
    rst = 1'b1; step(2); rst = 1'b0;
    step(31); chk("rst_mid_not_yet", key_state[6], 0);
    step(65); chk("rst_mid_pressed", key_state[6], 1);

    // random activity against the model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: begin rst = 1'b1; step(1); rst = 1'b0; end
        1: begin scan_en = 1'b0; step($urandom_range(5, 40)); scan_en = 1'b1; end
        2: keys = 16'($urandom);
        default: keys = keys ^ (16'h1 << $urandom_range(0, 15));
      endcase
      ev_ready = ($urandom_range(0, 3) != 0);
      step($urandom_range(10, 150));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
